// File: rtl/alu_381_slice_seq_if.sv
// Handshake and data bundle for the sliced 74381-style ALU.
// Names follow the classic part so that a cascade diagram can be read straight off the port list.
interface alu_381_slice_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       S;
  logic             Cn;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             P_n;
  logic             G_n;

  modport master (
    output in_valid, A, B, S, Cn, out_ready,
    input  in_ready, out_valid, F, cout, ovf, zero, P_n, G_n
  );

  modport slave (
    input  in_valid, A, B, S, Cn, out_ready,
    output in_ready, out_valid, F, cout, ovf, zero, P_n, G_n
  );
endinterface

// File: rtl/alu_381_slice_seq.sv
// Multi-cycle 74381-style ALU: one 4-bit slice per clock, LSB first, with the carry held between slices.
// state   | meaning
// IDLE    | ready for a new operation
// RUN     | processing slice cnt_q
// DONE    | result and flags presented, waiting for out_ready
module alu_381_slice_seq #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_381_slice_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = $clog2(NSLICE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, f_q;
  logic [2:0]       s_q;
  logic             p_acc_q, g_acc_q;
  logic             in_ready_q, out_valid_q;
  logic             cout_q, ovf_q, zero_q, pn_q, gn_q;

  logic             arith, last;
  logic [3:0]       a_sl, b_sl, ap, bp, pv, gv, f_sl;
  logic [4:0]       sum;
  logic             ps, gs, carry_d, p_acc_d, g_acc_d;
  logic [WIDTH-1:0] f_d;

  assign arith = (s_q == 3'b001) || (s_q == 3'b010) || (s_q == 3'b011);
  assign last  = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    a_sl = a_q[{cnt_q, 2'b00} +: 4];
    b_sl = b_q[{cnt_q, 2'b00} +: 4];
    ap   = (s_q == 3'b001) ? ~a_sl : a_sl;
    bp   = (s_q == 3'b010) ? ~b_sl : b_sl;
    sum  = {1'b0, ap} + {1'b0, bp} + {4'b0000, carry_q};
    pv   = ap | bp;
    gv   = ap & bp;
    ps   = &pv;
    gs   = gv[3] | (pv[3] & gv[2]) | (pv[3] & pv[2] & gv[1]) | (pv[3] & pv[2] & pv[1] & gv[0]);
    p_acc_d = p_acc_q & ps;
    g_acc_d = gs | (ps & g_acc_q);
    carry_d = carry_q;
    case (s_q)
      3'b000:  f_sl = 4'h0;
      3'b100:  f_sl = a_sl ^ b_sl;
      3'b101:  f_sl = a_sl | b_sl;
      3'b110:  f_sl = a_sl & b_sl;
      3'b111:  f_sl = 4'hF;
      default: begin
        f_sl    = sum[3:0];
        carry_d = sum[4];
      end
    endcase
    f_d = f_q;
    f_d[{cnt_q, 2'b00} +: 4] = f_sl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= 3'b000;
      f_q         <= '0;
      p_acc_q     <= 1'b1;
      g_acc_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b1;
      pn_q        <= 1'b1;
      gn_q        <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            s_q        <= bus.S;
            carry_q    <= bus.Cn;
            cnt_q      <= '0;
            p_acc_q    <= 1'b1;
            g_acc_q    <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          f_q     <= f_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + 1'b1;
          p_acc_q <= p_acc_d;
          g_acc_q <= g_acc_d;
          if (last) begin
            // Flags come from this edge's next-state values so they land together with the last slice.
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            cout_q      <= arith & carry_d;
            ovf_q       <= arith & (ap[3] == bp[3]) & (sum[3] != ap[3]);
            zero_q      <= (f_d == '0);
            pn_q        <= ~(arith & p_acc_d);
            gn_q        <= ~(arith & g_acc_d);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.F         = f_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.P_n       = pn_q;
  assign bus.G_n       = gn_q;
endmodule

// File: doc/alu_381_slice_seq.md
Name: alu_381_slice_seq

Overview:
- Parametrised, multi-cycle successor of the 4-bit 74381-style ALU.
- Takes WIDTH-bit operands and processes them in 4-bit slices, one slice per clock, from LSB slice to MSB slice.
- Carry is held in a register between slices.
- Valid/ready handshakes on input and output.
- Result word carries flags and active-low group propagate/generate for cascading into a look-ahead unit.

Parameters:
- WIDTH, 16: operand/result width; multiple of 4 and >= 8.
- NSLICE, WIDTH/4: derived slice count; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- S  in  3  opcode: 000 CLEAR, 001 B-A, 010 A-B, 011 A+B, 100 XOR, 101 OR, 110 AND, 111 PRESET.
- Cn  in  1  active-high carry into the LSB slice.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- F  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  two's-complement overflow.
- zero  out  1  F == 0.
- P_n  out  1  active-low group propagate.
- G_n  out  1  active-low group generate.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, in_ready=1, out_valid=0.
  - F=0, cout=0, ovf=0, zero=1, P_n=1, G_n=1.
  - Internal slice counter=0, carry=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture A, B, S and Cn. Carry reg=Cn, counter=0, P accumulator=1, G accumulator=0. Go to RUN.
  - RUN: in_ready=0. Each edge computes slice k=counter on bits [4k+3:4k] and writes F[4k+3:4k]. Carry reg takes that slice's carry out. counter+1. After slice NSLICE-1, go to DONE.
  - DONE: out_valid=1. All outputs held stable while out_ready=0. On out_ready=1, go to IDLE; out_valid falls next cycle.
- Latency and throughput:
  - Accept at edge T. out_valid is high in the cycle after edge T+NSLICE.
  - Throughput is one operation per NSLICE+2 cycles.
  - in_ready=0 in RUN and DONE. An in_valid asserted then is ignored, not queued.
- Arithmetic (per slice):
  - A+B: a'=A, b'=B.
  - A-B: a'=A, b'=~B.
  - B-A: a'=~A, b'=B.
  - Slice sum = a'+b'+carry, 5 bits wide; bit 4 becomes the new carry.
  - Subtract convention: Cn=1 gives the true difference. cout=1 means no borrow.
- Logic/constant operations:
  - XOR/OR/AND are bitwise per slice; carry reg is unchanged.
  - CLEAR gives F=0; PRESET gives F=all ones.
  - All four still take NSLICE cycles; latency is independent of opcode.
- Flags, valid in DONE:
  - cout = final carry reg for arithmetic ops, 0 otherwise.
  - ovf = (a'[MSB]==b'[MSB]) & (F[MSB]!=a'[MSB]) for arithmetic ops, 0 otherwise.
  - zero = (F==0) for every opcode.
- Group P/G (arithmetic ops only):
  - P accumulator ANDs p=a'|b' over all WIDTH bits.
  - G accumulator ripples per slice: G = g_slice | (p_slice & G_prev), where g_slice/p_slice are the 4-bit look-ahead generate/propagate of the slice. Final G equals the word carry-out with Cn=0.
  - P_n=~P, G_n=~G.
  - For CLEAR/XOR/OR/AND/PRESET: P_n=1, G_n=1.
- Simultaneous events:
  - out_ready=1 in the same cycle DONE is entered is honoured in that DONE cycle; out_valid stays high for exactly one cycle.
  - No bypass from DONE directly back into RUN.
- Reset mid-operation:
  - rst_n low in RUN or DONE aborts immediately to reset values.
  - The partial result is discarded; no out_valid is produced for it.
- Outputs F, cout, ovf, zero, P_n and G_n are registered.
- They may change during RUN; they are defined only while out_valid=1.

Test Plan (WIDTH=16):
- A+B with A=0x1234, B=0x0FCD, Cn=0 -> F=0x2201, cout=0, ovf=0, zero=0. out_valid rises exactly 4 cycles after the accept edge.
- A-B with A=0x0005, B=0x0007, Cn=1 -> F=0xFFFE, cout=0, ovf=0. Same operands as B-A -> F=0x0002, cout=1.
- A+B with A=0x7FFF, B=0x0001, Cn=0 -> F=0x8000, ovf=1, cout=0.
- A+B with A=0xFFFF, B=0x0001, Cn=0 -> F=0x0000, cout=1, zero=1, P_n=0, G_n=0. XOR on the same operands -> F=0xFFFE, P_n=1, G_n=1, cout=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> all outputs stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: drop rst_n after slice 2 -> outputs at reset values immediately. After release, a new CLEAR op -> F=0, zero=1, and no stale result is ever emitted.
